// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction-fetch front end. Holds the PC, reads words
//                from instruction memory and hands them to the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        misaligned_fault,
  output logic [31:0] retired_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [1:0] c_SEL_SEQ    = 2'b00;
  localparam logic [1:0] c_SEL_BRANCH = 2'b01;
  localparam logic [1:0] c_SEL_JALR   = 2'b10;
  localparam logic [1:0] c_SEL_HOLD   = 2'b11;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_fault;
  logic [31:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_target;
  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_redirect;
  logic        w_retire;
  logic        w_take_fault;
  logic        w_accept;
  logic        w_capture;

  assign w_pc_plus4    = r_pc + 32'd4;
  // JALR clears bit 0 only; a set bit 1 must still reach the alignment check.
  assign w_jalr_target = jump_target & ~32'd1;

  always_comb begin
    w_next_pc = r_pc;
    case (PC_sel)
      c_SEL_SEQ:    w_next_pc = w_pc_plus4;
      c_SEL_BRANCH: w_next_pc = branch_target;
      c_SEL_JALR:   w_next_pc = w_jalr_target;
      default:      w_next_pc = r_pc;
    endcase
  end

  assign w_misaligned = |w_next_pc[1:0];
  assign w_redirect   = (r_state == S_VALID) && advance && (PC_sel != c_SEL_HOLD);
  assign w_retire     = w_redirect && !w_misaligned;
  assign w_take_fault = w_redirect && w_misaligned;
  assign w_accept     = (r_state == S_REQ) && imem_ready;
  assign w_capture    = (r_state == S_WAIT) && imem_rvalid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ:   if (w_accept) w_next_state = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_next_state = S_VALID;
      S_VALID: begin
        if (w_take_fault) begin
          w_next_state = S_FAULT;
        end else if (w_retire) begin
          w_next_state = S_REQ;
        end
      end
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      S_REQ:   imem_req    = 1'b1;
      S_VALID: instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Datapath: PC, held instruction, fault flag and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_fault   <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_instr   <= NOP_INSTR;
        r_retired <= r_retired + 32'd1;
      end
      if (w_take_fault) begin
        r_fault <= 1'b1;
        r_instr <= NOP_INSTR;
      end
    end
  end

  assign imem_addr        = r_pc;
  assign PC               = r_pc;
  assign PC_plus4         = w_pc_plus4;
  assign Instruction      = r_instr;
  assign misaligned_fault = r_fault;
  assign retired_count    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  PC_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        misaligned_fault;
  logic [31:0] retired_count;

  int checks;
  int errors;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PC_sel           (PC_sel),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .advance          (advance),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .Instruction      (Instruction),
    .instr_valid      (instr_valid),
    .PC               (PC),
    .PC_plus4         (PC_plus4),
    .misaligned_fault (misaligned_fault),
    .retired_count    (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are settled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (instr_valid && imem_req) begin
      errors++;
      $display("FAIL excl: instr_valid=%0b imem_req=%0b required not both high", instr_valid, imem_req);
    end
  endtask

  // Zero-wait memory: accept the pending request, return data the next cycle.
  task automatic serve(input logic [31:0] data, input logic [31:0] exp_pc);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL serve_req: req=%0b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL serve_wait: req=%0b valid=%0b required 0 0", imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    checks++;
    if (instr_valid !== 1'b1 || Instruction !== data || PC !== exp_pc) begin
      errors++;
      $display("FAIL serve_valid: valid=%0b instr=%h pc=%h required 1 %h %h",
               instr_valid, Instruction, PC, data, exp_pc);
    end
  endtask

  task automatic do_advance(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] jt);
    advance       = 1'b1;
    PC_sel        = sel;
    branch_target = bt;
    jump_target   = jt;
    tick();
    advance       = 1'b0;
    PC_sel        = 2'b00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (PC !== 32'h0 || Instruction !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
        misaligned_fault !== 1'b0 || retired_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: pc=%h instr=%h valid=%0b req=%0b fault=%0b cnt=%0d",
               PC, Instruction, instr_valid, imem_req, misaligned_fault, retired_count);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        Instruction !== 32'h13 || retired_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_req: req=%0b addr=%h valid=%0b instr=%h cnt=%0d required 1 0 0 13 0",
               imem_req, imem_addr, instr_valid, Instruction, retired_count);
    end
  endtask

  task automatic test_sequential();
    serve(32'h5531_2023, 32'h0);
    checks++;
    if (PC_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL seq_plus4: got %h required 4", PC_plus4);
    end
    do_advance(2'b00, 32'h0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || PC_plus4 !== 32'h8 || retired_count !== 32'd1 ||
        instr_valid !== 1'b0 || Instruction !== 32'h13) begin
      errors++;
      $display("FAIL seq_next: req=%0b addr=%h plus4=%h cnt=%0d valid=%0b instr=%h",
               imem_req, imem_addr, PC_plus4, retired_count, instr_valid, Instruction);
    end
  endtask

  task automatic test_branch_jalr();
    serve(32'h0000_0063, 32'h4);
    do_advance(2'b01, 32'h40, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || retired_count !== 32'd2) begin
      errors++;
      $display("FAIL branch: req=%0b addr=%h cnt=%0d required 1 40 2", imem_req, imem_addr, retired_count);
    end
    serve(32'h0000_0067, 32'h40);
    do_advance(2'b10, 32'h0, 32'h101);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || retired_count !== 32'd3 || misaligned_fault !== 1'b0) begin
      errors++;
      $display("FAIL jalr: req=%0b addr=%h cnt=%0d fault=%0b required 1 100 3 0",
               imem_req, imem_addr, retired_count, misaligned_fault);
    end
  endtask

  task automatic test_hold_backpressure();
    serve(32'h0010_0093, 32'h100);
    advance = 1'b1;
    PC_sel  = 2'b11;
    tick();
    tick();
    advance = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h100 || retired_count !== 32'd3 || Instruction !== 32'h0010_0093) begin
      errors++;
      $display("FAIL hold: valid=%0b pc=%h cnt=%0d instr=%h required 1 100 3 00100093",
               instr_valid, PC, retired_count, Instruction);
    end
    do_advance(2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      PC_sel        = 2'b01;
      branch_target = 32'h800;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: req=%0b addr=%h valid=%0b required 1 104 0",
                 i, imem_req, imem_addr, instr_valid);
      end
    end
    PC_sel = 2'b00;
    serve(32'h0020_0113, 32'h104);
  endtask

  task automatic test_misalign();
    do_advance(2'b01, 32'h42, 32'h0);
    checks++;
    if (misaligned_fault !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h104 ||
        instr_valid !== 1'b0 || retired_count !== 32'd4) begin
      errors++;
      $display("FAIL misalign: fault=%0b req=%0b pc=%h valid=%0b cnt=%0d required 1 0 104 0 4",
               misaligned_fault, imem_req, PC, instr_valid, retired_count);
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (misaligned_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: fault=%0b req=%0b valid=%0b required 1 0 0",
                 i, misaligned_fault, imem_req, instr_valid);
      end
    end
    imem_ready = 1'b0;
    apply_reset();
    checks++;
    if (misaligned_fault !== 1'b0 || PC !== 32'h0 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL fault_clear: fault=%0b pc=%h cnt=%0d required 0 0 0", misaligned_fault, PC, retired_count);
    end
    tick();
    serve(32'h0000_0013, 32'h0);
    do_advance(2'b10, 32'h0, 32'h103);
    checks++;
    if (misaligned_fault !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h0) begin
      errors++;
      $display("FAIL jalr_bit1: fault=%0b req=%0b pc=%h required 1 0 0", misaligned_fault, imem_req, PC);
    end
    apply_reset();
    tick();
  endtask

  task automatic test_reset_midfetch();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    checks++;
    if (Instruction !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfetch: instr=%h valid=%0b req=%0b addr=%h required 13 0 1 0",
               Instruction, instr_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_hold: req=%0b valid=%0b required 1 0", imem_req, instr_valid);
    end
  endtask

  task automatic test_wrap();
    serve(32'h1234_5013, 32'h0);
    do_advance(2'b01, 32'hFFFF_FFFC, 32'h0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || PC_plus4 !== 32'h0 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL wrap_top: addr=%h plus4=%h cnt=%0d required fffffffc 0 1", imem_addr, PC_plus4, retired_count);
    end
    serve(32'h0000_0013, 32'hFFFF_FFFC);
    do_advance(2'b00, 32'h0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retired_count !== 32'd2 || misaligned_fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc: req=%0b addr=%h cnt=%0d fault=%0b required 1 0 2 0",
               imem_req, imem_addr, retired_count, misaligned_fault);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    PC_sel        = 2'b00;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    advance       = 1'b0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    test_reset();
    test_sequential();
    test_branch_jalr();
    test_hold_backpressure();
    test_misalign();
    test_reset_midfetch();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
